// File: rtl/alu_iter_md.sv
// -----------------------------------------------------------------------------
// alu_iter_md
//
// Execute-stage ALU with a valid/ready handshake on both sides. Single-cycle
// integer ops (ADD, SLL, SUB, SLT, XOR, SRL, OR, AND, SRA, SLTU) produce a
// registered result one cycle after acceptance. The RV32M-style ops (MUL,
// MULHU, DIV, DIVU, REM, REMU) run on an iterative radix-2 datapath: WIDTH
// shift-add / restoring-subtract steps followed by one sign-fix cycle.
// Result and flags are registered and held until the consumer takes them.
//
// Configuration macro:
//   ALU_ITER_MD_EN  defined   -> iterative MUL/DIV path and busy logic present.
//                   undefined -> opcodes 1010-1111 finish in one cycle with
//                                result 0 (zf=1, other flags 0), busy tied 0,
//                                no multiply/divide datapath.
//
// Parameters:
//   WIDTH  datapath width (power of two, >= 8)
//   SHW    shift-amount bits taken from src_b[SHW-1:0]
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered            in_ready   unit can accept
//   op         4-bit opcode                 src_a/b    operands
//   out_valid  result and flags valid       out_ready  consumer accepts result
//   result     registered result
//   zf/sf      zero / sign of result
//   cf         ADD carry-out, SUB borrow, else 0
//   of         ADD/SUB signed overflow, else 0
//   busy       iterative operation in progress
// -----------------------------------------------------------------------------
module alu_iter_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zf,
  output logic             sf,
  output logic             cf,
  output logic             of,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;

  logic             accept;
  logic             load_res;
  logic [WIDTH-1:0] new_res;
  logic             new_cf;
  logic             new_of;

  // ---------------------------------------------------------------------------
  // Handshake. DONE acts like IDLE while its result is being drained, so a
  // result can leave and a new op enter on the same edge.
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q == S_DONE);
  assign in_ready  = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                     (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;

  assign result = result_q;
  assign zf     = zf_q;
  assign sf     = sf_q;
  assign cf     = cf_q;
  assign of     = of_q;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf;
  logic             alu_of;

  assign shamt    = src_b[SHW-1:0];
  assign add_full = {1'b0, src_a} + {1'b0, src_b};
  // Top bit of the widened difference is the unsigned borrow.
  assign sub_full = {1'b0, src_a} - {1'b0, src_b};

  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (op)
      4'b0000: begin
        alu_res = add_full[WIDTH-1:0];
        alu_cf  = add_full[WIDTH];
        alu_of  = (src_a[WIDTH-1] == src_b[WIDTH-1]) &&
                  (add_full[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'b0001: alu_res = src_a << shamt;
      4'b0010: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_cf  = sub_full[WIDTH];
        alu_of  = (src_a[WIDTH-1] != src_b[WIDTH-1]) &&
                  (sub_full[WIDTH-1] != src_a[WIDTH-1]);
      end
      4'b0011: alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'b0100: alu_res = src_a ^ src_b;
      4'b0101: alu_res = src_a >> shamt;
      4'b0110: alu_res = src_a | src_b;
      4'b0111: alu_res = src_a & src_b;
      4'b1000: alu_res = $unsigned($signed(src_a) >>> shamt);
      4'b1001: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      // M-extension opcodes: zero here; the iterative path overrides when built.
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_ITER_MD_EN
  // ---------------------------------------------------------------------------
  // Iterative multiply / divide datapath
  //
  // hi_q/lo_q form a 2*WIDTH working register:
  //   MUL: hi = partial product, lo = multiplier shifting out LSB-first
  //   DIV: hi = partial remainder, lo = dividend shifting into quotient
  // opd_q holds the multiplicand or the divisor magnitude.
  // ---------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [2:0]       op_q, op_d;
  logic             quot_neg_q, quot_neg_d;
  logic             rem_neg_q, rem_neg_d;

  logic             is_md;
  logic             is_div;
  logic             div_signed;
  logic             div_zero;
  logic             div_ovf;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] special_res;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] fix_res;

  assign is_md      = op[3] && (op[2] || op[1]);
  assign is_div     = op[3] && op[2];
  assign div_signed = is_div && !op[0];
  assign div_zero   = is_div && (src_b == '0);
  assign div_ovf    = div_signed && (src_a == MOST_NEG) && (src_b == '1);

  assign mag_a = (div_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign mag_b = (div_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // op[1] selects remainder among the divide opcodes.
  always_comb begin
    special_res = '0;
    if (div_zero) begin
      special_res = op[1] ? src_a : '1;
    end else begin
      special_res = op[1] ? '0 : MOST_NEG;
    end
  end

  // Shift-add: carry out of the add becomes the new top bit after shifting.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
  // Restoring divide: remainder needs one extra bit before the trial subtract.
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, opd_q};

  always_comb begin
    fix_res = '0;
    if (!op_q[2]) begin
      fix_res = op_q[0] ? hi_q : lo_q;
    end else if (!op_q[1]) begin
      fix_res = quot_neg_q ? -lo_q : lo_q;
    end else begin
      fix_res = rem_neg_q ? -hi_q : hi_q;
    end
  end

  assign busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opd_q      <= '0;
      op_q       <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      opd_q      <= opd_d;
      op_q       <= op_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end
`else
  assign busy = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    new_res  = '0;
    new_cf   = 1'b0;
    new_of   = 1'b0;
`ifdef ALU_ITER_MD_EN
    count_d    = count_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    opd_d      = opd_q;
    op_d       = op_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          state_d  = S_DONE;
          load_res = 1'b1;
          new_res  = alu_res;
          new_cf   = alu_cf;
          new_of   = alu_of;
`ifdef ALU_ITER_MD_EN
          if (is_md) begin
            new_cf = 1'b0;
            new_of = 1'b0;
            if (div_zero || div_ovf) begin
              new_res = special_res;
            end else begin
              load_res = 1'b0;
              state_d  = is_div ? S_DIV : S_MUL;
              count_d  = SHW'(WIDTH - 1);
              op_d     = op[2:0];
              hi_d     = '0;
              if (is_div) begin
                lo_d       = mag_a;
                opd_d      = mag_b;
                quot_neg_d = div_signed && (src_a[WIDTH-1] != src_b[WIDTH-1]);
                rem_neg_d  = div_signed && src_a[WIDTH-1];
              end else begin
                lo_d       = src_b;
                opd_d      = src_a;
                quot_neg_d = 1'b0;
                rem_neg_d  = 1'b0;
              end
            end
          end
`endif
        end
      end
`ifdef ALU_ITER_MD_EN
      S_MUL: begin
        hi_d = mul_sum[WIDTH:1];
        lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        if (count_q == '0) begin
          state_d = S_FIX;
        end else begin
          count_d = count_q - SHW'(1);
        end
      end
      S_DIV: begin
        if (!div_trial[WIDTH]) begin
          hi_d = div_trial[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (count_q == '0) begin
          state_d = S_FIX;
        end else begin
          count_d = count_q - SHW'(1);
        end
      end
      S_FIX: begin
        load_res = 1'b1;
        new_res  = fix_res;
        state_d  = S_DONE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Flags derive from the value being loaded so they always match result.
  always_comb begin
    result_d = result_q;
    zf_d     = zf_q;
    sf_d     = sf_q;
    cf_d     = cf_q;
    of_d     = of_q;
    if (load_res) begin
      result_d = new_res;
      zf_d     = (new_res == '0);
      sf_d     = new_res[WIDTH-1];
      cf_d     = new_cf;
      of_d     = new_of;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zf_q     <= 1'b1;
      sf_q     <= 1'b0;
      cf_q     <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      sf_q     <= sf_d;
      cf_q     <= cf_d;
      of_q     <= of_d;
    end
  end

endmodule

// File: tb/tb_alu_iter_md.sv
// -----------------------------------------------------------------------------
// tb_alu_iter_md
//
// Bench for alu_iter_md (WIDTH=32). A reference model computes each op's
// result, flags and latency from plain arithmetic; a compare process checks
// out_valid, in_ready, busy, result and flags against it at every falling
// edge. Directed transactions with hand-computed values pin the model, then
// a randomized phase exercises back-to-back traffic and backpressure, and a
// reset is fired in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_alu_iter_md;

  localparam int W = 32;
`ifdef ALU_ITER_MD_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif
  localparam int     LMD  = W + 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zf, sf, cf, of, busy;

  int checks   = 0;
  int failures = 0;

  alu_iter_md #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zf        (zf),
    .sf        (sf),
    .cf        (cf),
    .of        (of),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: result, carry, overflow and latency of one operation.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic c, output logic v,
                                output int lat);
    longint sa, sb, t;
    logic [63:0] p;
    logic [32:0] w;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    r   = '0;
    c   = 1'b0;
    v   = 1'b0;
    lat = 1;
    t   = 0;
    case (o)
      4'd0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[31:0];
        c = w[32];
        t = sa + sb;
        v = (t > SMAX) || (t < SMIN);
      end
      4'd1: r = a << b[4:0];
      4'd2: begin
        r = a - b;
        c = (a < b);
        t = sa - sb;
        v = (t > SMAX) || (t < SMIN);
      end
      4'd3: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd4: r = a ^ b;
      4'd5: r = a >> b[4:0];
      4'd6: r = a | b;
      4'd7: r = a & b;
      4'd8: r = $signed(a) >>> b[4:0];
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      4'd10, 4'd11: begin
        p   = {32'b0, a} * {32'b0, b};
        r   = (o == 4'd10) ? p[31:0] : p[63:32];
        lat = LMD;
      end
      default: begin
        if (b == 0) begin
          r = (o == 4'd12 || o == 4'd13) ? 32'hFFFFFFFF : a;
        end else if (o == 4'd12 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          r = 32'h80000000;
        end else if (o == 4'd14 && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          r = 32'h0;
        end else begin
          lat = LMD;
          case (o)
            4'd12:   begin t = sa / sb; r = t[31:0]; end
            4'd13:   r = a / b;
            4'd14:   begin t = sa % sb; r = t[31:0]; end
            default: r = a % b;
          endcase
        end
      end
    endcase
    if (!EN && o >= 4'd10) begin
      r   = '0;
      c   = 1'b0;
      v   = 1'b0;
      lat = 1;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Cycle-by-cycle compare against the model. m_wait counts cycles until a
  // pending iterative result appears; m_valid means a result is being held.
  // ---------------------------------------------------------------------------
  logic        m_valid = 1'b0;
  int          m_wait  = 0;
  logic [31:0] m_res, p_res, t_res;
  logic        m_cf, m_of, p_cf, p_of, t_cf, t_of;
  logic        exp_ready;
  int          t_lat;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_wait  = 0;
    end else begin
      exp_ready = (m_wait == 0) && (!m_valid || out_ready);
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, EN && (m_wait != 0));
      if (m_valid) begin
        chk("result", result, m_res);
        chk("zf", zf, (m_res == 0));
        chk("sf", sf, m_res[31]);
        chk("cf", cf, m_cf);
        chk("of", of, m_of);
      end
      // advance the model across the coming rising edge
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_wait != 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          m_res   = p_res;
          m_cf    = p_cf;
          m_of    = p_of;
        end
      end
      if (in_valid && exp_ready) begin
        model(op, src_a, src_b, t_res, t_cf, t_of, t_lat);
        if (t_lat == 1) begin
          m_valid = 1'b1;
          m_res   = t_res;
          m_cf    = t_cf;
          m_of    = t_of;
        end else begin
          m_wait = t_lat - 1;
          p_res  = t_res;
          p_cf   = t_cf;
          p_of   = t_of;
        end
      end
    end
  end

  // One directed transaction with out_ready held high; returns the result
  // and {zf,sf,cf,of} as seen on the first cycle out_valid is high.
  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_lat, input string nm,
                       output logic [31:0] r, output logic [3:0] fl);
    int n;
    int lat;
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    op        = o;
    src_a     = a;
    src_b     = b;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk({nm, "_accept_timeout"}, (n < 100), 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r  = result;
    fl = {zf, sf, cf, of};
    chk(nm, r, exp_r);
    chk({nm, "_latency"}, lat, exp_lat);
    $display("txn %s op=%h a=%h b=%h result=%h flags=%b latency=%0d", nm, o, a, b, r, fl, lat);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'h7FFFFFFF;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] r;
  logic [3:0]  fl;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    src_a     = '0;
    src_b     = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {zf, sf, cf, of}, 4'b1000);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // hand-computed transactions
    do_op(4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1, "add_carry", r, fl);
    chk("add_carry_flags", fl, 4'b1010);
    do_op(4'd2, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1, "sub_ovf", r, fl);
    chk("sub_ovf_flags", fl, 4'b0111);
    do_op(4'd8, 32'h80000000, 32'h00000024, 32'hF8000000, 1, "sra", r, fl);
    do_op(4'd3, 32'hFFFFFFFF, 32'h00000001, 32'h1, 1, "slt", r, fl);
    do_op(4'd9, 32'hFFFFFFFF, 32'h00000001, 32'h0, 1, "sltu", r, fl);
    do_op(4'd10, 32'h00012345, 32'h00006789, EN ? 32'h75CCA2ED : 32'h0,
          EN ? 34 : 1, "mul", r, fl);
    do_op(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, EN ? 32'hFFFFFFFE : 32'h0,
          EN ? 34 : 1, "mulhu", r, fl);
    do_op(4'd12, 32'hFFFFFFF9, 32'h00000002, EN ? 32'hFFFFFFFD : 32'h0,
          EN ? 34 : 1, "div_neg", r, fl);
    do_op(4'd14, 32'hFFFFFFF9, 32'h00000002, EN ? 32'hFFFFFFFF : 32'h0,
          EN ? 34 : 1, "rem_neg", r, fl);
    do_op(4'd13, 32'h00000005, 32'h00000000, EN ? 32'hFFFFFFFF : 32'h0, 1, "divu_zero", r, fl);
    do_op(4'd12, 32'h80000000, 32'hFFFFFFFF, EN ? 32'h80000000 : 32'h0, 1, "div_ovf", r, fl);
    do_op(4'd15, 32'h00000064, 32'h00000007, EN ? 32'h00000002 : 32'h0,
          EN ? 34 : 1, "remu", r, fl);

    // backpressure: hold the result, then drain and accept on the same edge
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    op        = 4'd2;
    src_a     = 32'h7FFFFFFF;
    src_b     = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_result", result, 32'h80000000);
      chk("bp_flags", {zf, sf, cf, of}, 4'b0111);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b1;
    op        = 4'd0;
    src_a     = 32'd3;
    src_b     = 32'd4;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_drain_accept_valid", out_valid, 1'b1);
    chk("bp_drain_accept_result", result, 32'd7);
    $display("txn backpressure drain+accept result=%h", result);

    // randomized traffic, checked by the compare process
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 4'($urandom_range(0, 15));
      src_a     = pick();
      src_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : pick();
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);

    // reset in the middle of a divide
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    op       = 4'd12;
    src_a    = 32'd100;
    src_b    = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_div_busy", busy, EN);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_zf", zf, 1'b1);
    chk("midrst_result", result, 32'h0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    do_op(4'd0, 32'd3, 32'd4, 32'd7, 1, "add_after_reset", r, fl);
    chk("add_after_reset_flags", fl, 4'b0000);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
